// File: rtl/umi_fifo_arbiter.sv
// umi_fifo_arbiter: round-robin arbiter that shares one UMI FIFO write port
// among N requesters. The winner is registered into a single-entry output
// stage. That stage refills in the same cycle it drains, so one transaction
// per cycle is sustained while downstream is ready.
module umi_fifo_arbiter #(
    parameter int N  = 4,
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready,
    output logic [N-1:0]    arb_grant
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [CW-1:0] cmd_q, cmd_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] src_q, src_d;
    logic [DW-1:0] data_q, data_d;

    logic [N-1:0]  grant;
    logic [PW-1:0] win_idx;
    logic [PW:0]   scan;
    logic          any_vld;
    logic          load_en;
    logic          hs;
    logic [CW-1:0] mux_cmd;
    logic [AW-1:0] mux_dst;
    logic [AW-1:0] mux_src;
    logic [DW-1:0] mux_data;

    // Stage can take a new word when it is empty or is being drained now.
    assign load_en = ~out_valid_q | umi_out_ready;
    assign hs      = load_en & any_vld;

    // Grant goes to the first valid requester at or after the pointer, modulo N.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        any_vld = 1'b0;
        scan    = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(N)) scan = scan - (PW+1)'(N);
            if (!any_vld && umi_in_valid[scan[PW-1:0]]) begin
                any_vld = 1'b1;
                win_idx = scan[PW-1:0];
            end
        end
        grant[win_idx] = any_vld;
    end

    // Select the granted requester's fields. The grant is one-hot, so at most one term applies.
    always_comb begin
        mux_cmd  = '0;
        mux_dst  = '0;
        mux_src  = '0;
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                mux_cmd  = umi_in_cmd[i*CW +: CW];
                mux_dst  = umi_in_dstaddr[i*AW +: AW];
                mux_src  = umi_in_srcaddr[i*AW +: AW];
                mux_data = umi_in_data[i*DW +: DW];
            end
        end
    end

    // Accept strobe. It is suppressed during reset so no partial handshake is acknowledged.
    assign umi_in_ready = (load_en && !reset) ? grant : '0;

    // Output-stage and pointer next state.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        grant_d     = grant_q;
        cmd_d       = cmd_q;
        dst_d       = dst_q;
        src_d       = src_q;
        data_d      = data_q;
        if (hs) begin
            out_valid_d = 1'b1;
            grant_d     = grant;
            cmd_d       = mux_cmd;
            dst_d       = mux_dst;
            src_d       = mux_src;
            data_d      = mux_data;
            ptr_d       = (win_idx == PW'(N-1)) ? '0 : win_idx + 1'b1;
        end else if (load_en) begin
            // Drained, or already empty, with nothing to refill. Payload fields hold.
            out_valid_d = 1'b0;
            grant_d     = '0;
        end
    end

    // State registers with synchronous reset. A held word is discarded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            cmd_q       <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            data_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
            cmd_q       <= cmd_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            data_q      <= data_d;
        end
    end

    assign umi_out_valid   = out_valid_q;
    assign umi_out_cmd     = cmd_q;
    assign umi_out_dstaddr = dst_q;
    assign umi_out_srcaddr = src_q;
    assign umi_out_data    = data_q;
    assign arb_grant       = grant_q;

endmodule

// File: tb/tb_umi_fifo_arbiter.sv
// Bench for umi_fifo_arbiter: a directed vector table covers reset, grant
// order, stall, wrap and mid-operation reset. A random phase then runs with a
// scoreboard that checks loss, duplication, ordering and wait bound.
module tb_umi_fifo_arbiter;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 256;

    logic            clk;
    logic            reset;
    logic [N-1:0]    umi_in_valid;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic            umi_out_ready;
    logic [N-1:0]    arb_grant;

    umi_fifo_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready),
        .arb_grant       (arb_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [3:0] e_g;
        logic [7:0] e_cmd;
    } vec_t;

    typedef struct packed {
        logic [N-1:0]  g;
        logic [DW-1:0] d;
    } sb_t;

    int errors = 0;
    int checks = 0;

    vec_t vecs [27];
    logic [7:0] cmd_c [4] = '{8'hA0, 8'hA1, 8'hA5, 8'hA3};

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] dst_of(input int i);
        return 64'hD000_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [AW-1:0] src_of(input int i);
        return 64'h5000_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [DW-1:0] dat_of(input int i);
        return {8{32'hDA7A_0000 | 32'(i)}};
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        int r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    logic [N-1:0] rv;
    int           seq  [N];
    int           wcnt [N];
    int           maxw;
    sb_t          q [$];
    sb_t          e;

    // One random-phase cycle: drive, consume the held word, record the accept.
    task automatic rnd_cycle(input bit gen, input bit drain);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (gen && !rv[i] && $urandom_range(1) == 1) rv[i] = 1'b1;
            umi_in_data[i*DW +: DW] = DW'({8'(i), 8'h00, 16'(seq[i])});
        end
        umi_in_valid  = rv;
        umi_out_ready = drain ? 1'b1 : ($urandom_range(3) != 0);
        #1;
        if (umi_out_valid && umi_out_ready) begin
            if (q.size() == 0) begin
                chk("sb_dup", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sb_grant", 256'(arb_grant), 256'(e.g));
                chk("sb_data", umi_out_data, e.d);
            end
        end
        chk("rdy_legal", 256'(((umi_in_ready & ~umi_in_valid) == '0) && $onehot0(umi_in_ready)), 256'(1));
        for (int i = 0; i < N; i++) begin
            if (umi_in_valid[i] && umi_in_ready[i]) begin
                e.g = N'(1) << i;
                e.d = DW'({8'(i), 8'h00, 16'(seq[i])});
                q.push_back(e);
                seq[i]++;
                rv[i] = 1'b0;
                wcnt[i] = 0;
                for (int j = 0; j < N; j++) begin
                    if (j != i && rv[j]) begin
                        wcnt[j]++;
                        if (wcnt[j] > maxw) maxw = wcnt[j];
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        umi_in_valid = '0;
        umi_out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            umi_in_cmd[i*CW +: CW]     = {24'h0, cmd_c[i]};
            umi_in_dstaddr[i*AW +: AW] = dst_of(i);
            umi_in_srcaddr[i*AW +: AW] = src_of(i);
            umi_in_data[i*DW +: DW]    = dat_of(i);
        end

        //                rst   vld     ordy  e_rdy   e_ov  e_g     e_cmd
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'hA1};
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'hA5};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'hA3};
        vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'hA1};
        vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'hA5};
        vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'hA3};
        vecs[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'hA3};
        vecs[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'hA5};
        vecs[11] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'hA3};
        vecs[12] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001, 8'hA0};
        vecs[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001, 8'hA0};
        vecs[15] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001, 8'hA0};
        vecs[16] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001, 8'hA0};
        vecs[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001, 8'hA0};
        vecs[18] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'hA1};
        vecs[19] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0010, 8'hA1};
        vecs[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'hA1};
        vecs[21] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'b1000, 8'hA3};
        vecs[22] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};
        vecs[23] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[24] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'hA1};
        vecs[25] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[26] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'hA0};

        repeat (2) @(posedge clk);

        for (int v = 0; v < 27; v++) begin
            @(negedge clk);
            reset         = vecs[v].rst;
            umi_in_valid  = vecs[v].vld;
            umi_out_ready = vecs[v].ordy;
            #1;
            chk($sformatf("v%0d in_ready", v), 256'(umi_in_ready), 256'(vecs[v].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", v), 256'(umi_out_valid), 256'(vecs[v].e_ov));
            chk($sformatf("v%0d arb_grant", v), 256'(arb_grant), 256'(vecs[v].e_g));
            chk($sformatf("v%0d out_cmd", v), 256'(umi_out_cmd), 256'(vecs[v].e_cmd));
            if (vecs[v].e_ov) begin
                chk($sformatf("v%0d dstaddr", v), 256'(umi_out_dstaddr), 256'(dst_of(idx_of(vecs[v].e_g))));
                chk($sformatf("v%0d srcaddr", v), 256'(umi_out_srcaddr), 256'(src_of(idx_of(vecs[v].e_g))));
                chk($sformatf("v%0d data", v), umi_out_data, dat_of(idx_of(vecs[v].e_g)));
            end
        end

        // Random phase begins from a clean reset so the scoreboard starts empty.
        @(negedge clk);
        reset = 1'b1;
        umi_in_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        rv = '0;
        maxw = 0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            wcnt[i] = 0;
        end
        for (int c = 0; c < 10000; c++) rnd_cycle(1'b1, 1'b0);
        for (int c = 0; c < 3 * N; c++) rnd_cycle(1'b0, 1'b1);
        @(negedge clk);
        umi_in_valid = '0;
        #1;
        chk("sb_empty", 256'(q.size()), 256'(0));
        chk("sb_out_idle", 256'(umi_out_valid), 256'(0));
        chk("max_wait", 256'(maxw <= N - 1), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
